// File: rtl/sdram_burst_reader_if.sv
// Read-side bus of the burst reader: controller read port plus the
// valid/ready stream toward the consumer.
interface sdram_burst_reader_if;
  logic        rd_request;
  logic [22:0] rd_address;
  logic [8:0]  rd_burst_length;
  logic        rd_available;
  logic [31:0] rd_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  modport master (
    output rd_request, rd_address, rd_burst_length, out_valid, out_data,
    input  rd_available, rd_data, out_ready
  );

  modport slave (
    input  rd_request, rd_address, rd_burst_length, out_valid, out_data,
    output rd_available, rd_data, out_ready
  );
endinterface

// File: rtl/sdram_burst_reader.sv
// Splits a (address, word count) read command into row-bounded controller
// bursts and buffers the returned words in a first-word-fall-through FIFO.
module sdram_burst_reader #(
  parameter int FIFO_DEPTH = 512,
  parameter int MAX_BURST  = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [22:0] start_address_i,
  input  logic [15:0] word_count_i,
  output logic        busy_o,
  output logic        done_o,
  sdram_burst_reader_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [8:0] MAXB = 9'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, ISSUE, REQUEST, STREAM} state_t;

  state_t      state_q, state_d;
  logic [22:0] cur_addr_q, cur_addr_d;
  logic [15:0] remain_q, remain_d;
  logic [22:0] rd_addr_q, rd_addr_d;
  logic [8:0]  blen_q, blen_d;
  logic [8:0]  recv_q, recv_d;
  logic        done_q, done_d;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          stg_vld_q;
  logic [31:0]   stg_data_q;

  logic [8:0]  row_room, rem_cap, cap1, len;
  logic [16:0] free_w;
  logic        space_ok, accept, burst_end, push, pop, fifo_nempty;

  // Burst length is bounded by what is left, MAX_BURST, and the row end,
  // since the controller wraps full-page bursts within the open row.
  always_comb begin
    row_room = 9'd256 - {1'b0, cur_addr_q[9:2]};
    rem_cap  = (remain_q > 16'd256) ? 9'd256 : remain_q[8:0];
    cap1     = (rem_cap > MAXB) ? MAXB : rem_cap;
    len      = (cap1 > row_room) ? row_room : cap1;
    free_w   = 17'(FIFO_DEPTH) - 17'(cnt_q);
    space_ok = free_w >= {8'b0, len};
  end

  assign accept    = (state_q == STREAM) && bus.rd_available && (recv_q != blen_q);
  assign burst_end = (state_q == STREAM) && !bus.rd_available && (recv_q == blen_q);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    rd_addr_d  = rd_addr_q;
    blen_d     = blen_q;
    recv_d     = recv_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (word_count_i == 16'd0) begin
            done_d = 1'b1;
          end else begin
            cur_addr_d = start_address_i & 23'h7FFFFC;
            remain_d   = word_count_i;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (space_ok) begin
          rd_addr_d = cur_addr_q;
          blen_d    = len;
          state_d   = REQUEST;
        end
      end
      REQUEST: begin
        recv_d  = 9'd0;
        state_d = STREAM;
      end
      STREAM: begin
        if (accept) begin
          recv_d = recv_q + 9'd1;
        end else if (burst_end) begin
          // Plain 23-bit add carries column into row and bank, bank 3 wraps to 0.
          cur_addr_d = cur_addr_q + {12'b0, blen_q, 2'b00};
          remain_d   = remain_q - {7'b0, blen_q};
          if (remain_q == {7'b0, blen_q}) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      remain_q   <= '0;
      rd_addr_q  <= '0;
      blen_q     <= '0;
      recv_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      remain_q   <= remain_d;
      rd_addr_q  <= rd_addr_d;
      blen_q     <= blen_d;
      recv_q     <= recv_d;
      done_q     <= done_d;
    end
  end

  // Returned words pass through one staging register before the FIFO array,
  // so a word becomes visible one cycle after it is captured.
  assign fifo_nempty = (cnt_q != '0);
  assign push        = stg_vld_q;
  assign pop         = fifo_nempty && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_vld_q  <= 1'b0;
      stg_data_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      stg_vld_q  <= accept;
      stg_data_q <= accept ? bus.rd_data : stg_data_q;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= stg_data_q;
  end

  assign busy_o              = (state_q != IDLE);
  assign done_o              = done_q;
  assign bus.rd_request      = (state_q == REQUEST);
  assign bus.rd_address      = rd_addr_q;
  assign bus.rd_burst_length = blen_q;
  assign bus.out_valid       = fifo_nempty;
  assign bus.out_data        = fifo_nempty ? mem[rptr_q] : 32'd0;

endmodule
